mem_access_unit: RTL

Parametrised data-memory stage for the pipelined CPU, successor to the single-cycle word-only MEM stage. Accepts one load or store per request over a valid/ready handshake and supports byte, halfword and word accesses with byte-lane writes and sign/zero-extended loads. Load latency is configurable, misaligned or out-of-range accesses are flagged, and branch resolution covers BEQ/BNE/BLT/BGE. Sits between the EX/MEM and MEM/WB pipeline registers; `stall` back-pressures the pipeline.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_byte_ram.sv | 43 ++++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory stage: access sizes, branch modes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4
  } br_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_byte_ram.sv
// DEPTH x 32 data RAM with byte-lane write enables and a synchronous read port.
// Latency: read data valid the cycle after re; debug read is one registered cycle.
// Backpressure: none; optional debug port enabled by MEM_DBG_PORT_EN.
module mem_byte_ram
  import mem_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes and registered read; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

`ifdef MEM_DBG_PORT_EN
  // Second read port: same-edge writes show the old word, new data one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_data <= '0;
    else        dbg_data <= mem[dbg_addr];
  end
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_addr, rst_n};
  assign dbg_data   = '0;
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory stage: byte/half/word loads and stores with error flagging, plus branch decision.
// Latency: stores/errors respond 1 cycle after accept, loads LOAD_LAT cycles after accept.
// Backpressure: req_ready low while a multi-cycle load waits; stall = req_valid & ~req_ready.
// Optional debug read port: MEM_DBG_PORT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter  int DEPTH    = 256,
  parameter  int LOAD_LAT = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall,
  input  logic [2:0]        br_mode,
  input  logic              alu_zero,
  input  logic              alu_lt,
  output logic              br_taken,
  input  logic [AW-1:0]     dbg_addr,
  output logic [31:0]       dbg_data
);

  mem_state_e        state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic              accept, is_err;
  logic [3:0]        lane_en;
  logic [DATA_W-1:0] wdata_rep, ram_rdata, ext;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;
  logic              q_we, q_err, q_uns;
  logic [1:0]        q_size, q_lane;

  assign req_ready  = (state != WAIT);
  assign stall      = req_valid & ~req_ready;
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state == RESP);

  // Legality check plus byte-lane enables and store-data replication for narrow stores.
  always_comb begin
    is_err    = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    lane_en   = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      BYTE: begin
        lane_en[req_addr[1:0]] = 1'b1;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      HALF: begin
        is_err    = is_err | req_addr[0];
        lane_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      WORD: begin
        is_err  = is_err | (req_addr[1:0] != 2'b00);
        lane_en = 4'b1111;
      end
      default: is_err = 1'b1;
    endcase
  end

  mem_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       ((accept & req_we & ~is_err) ? lane_en : 4'b0000),
    .re       (accept & ~req_we & ~is_err),
    .addr     (req_addr[AW+1:2]),
    .wdata    (wdata_rep),
    .rdata    (ram_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: only error-free loads with LOAD_LAT>1 pass through WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        state_nxt = IDLE;
        if (accept) begin
          if (LOAD_LAT > 1 && !req_we && !is_err) begin
            state_nxt = WAIT;
            cnt_nxt   = 2'(LOAD_LAT - 2);
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 2'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture per-request attributes needed to shape the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_we   <= 1'b0;
      q_err  <= 1'b0;
      q_uns  <= 1'b0;
      q_size <= 2'd0;
      q_lane <= 2'd0;
    end else if (accept) begin
      q_we   <= req_we;
      q_err  <= is_err;
      q_uns  <= req_unsigned;
      q_size <= req_size;
      q_lane <= req_addr[1:0];
    end
  end

  // Lane select and sign/zero extension on the held RAM word.
  always_comb begin
    half_sel = q_lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    byte_sel = ram_rdata[{q_lane, 3'b000} +: 8];
    case (q_size)
      BYTE:    ext = {{24{~q_uns & byte_sel[7]}}, byte_sel};
      HALF:    ext = {{16{~q_uns & half_sel[15]}}, half_sel};
      default: ext = ram_rdata;
    endcase
    resp_rdata = (resp_valid && !q_we && !q_err) ? ext : '0;
  end

  assign resp_err = resp_valid & q_err;

  // Branch decision from ALU flags, independent of the memory FSM.
  always_comb begin
    case (br_mode)
      BR_EQ:   br_taken = alu_zero;
      BR_NE:   br_taken = ~alu_zero;
      BR_LT:   br_taken = alu_lt;
      BR_GE:   br_taken = ~alu_lt;
      default: br_taken = 1'b0;
    endcase
  end

endmodule
